mod14_count_ctrl: RTL and testbench

- Command sequencer for the mod-14 up/down counter (`data_in[3:0]`, `load`, `mode`, `reset_n`, `data_out[3:0]`).
- Accepts LOAD / UP / DOWN / CLEAR commands through a valid/ready port and buffers them in a small FIFO.
- Drives the counter's control pins cycle by cycle to execute each command, then reports the resulting count.
- The counter always advances unless loaded, so between commands this block parks it by reloading its own output.

---
 rtl/mod14_count_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mod14_count_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod14_count_ctrl.sv
// ============================================================================
// Module      : mod14_count_ctrl
// Description : Queues LOAD/UP/DOWN/CLEAR commands and drives a mod-14
//               up/down counter's control pins to execute them one by one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod14_count_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_VAL    = 13
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [3:0]                    cmd_arg,
    output logic [3:0]                    ctr_data_in,
    output logic                          ctr_load,
    output logic                          ctr_mode,
    output logic                          ctr_reset_n,
    input  logic [3:0]                    ctr_data_out,
    output logic                          done,
    output logic [3:0]                    done_value,
    output logic                          err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    localparam logic [3:0] MAX_ARG  = 4'(MAX_VAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     op_q;
    logic [3:0]     arg_q;
    logic [3:0]     steps_q, steps_d;
    logic           mode_q;

    logic           w_push, w_pop, w_full, w_empty;
    logic           w_load, w_mode, w_rst;
    logic [3:0]     w_data;

    assign w_full     = (count_q == CW'(FIFO_DEPTH));
    assign w_empty    = (count_q == '0);
    assign cmd_ready  = reset_n & ~w_full;
    assign w_push     = cmd_valid & cmd_ready;
    assign w_pop      = ~w_empty & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) | ~w_empty;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_arg};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            op_q     <= OP_LOAD;
            arg_q    <= '0;
            steps_q  <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            steps_q <= steps_d;
            mode_q  <= w_mode;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q       <= rd_ptr_q + AW'(1);
                {op_q, arg_q}  <= mem_q[rd_ptr_q];
            end
        end
    end

    // Idle and done cycles reload the counter with its own output to park it.
    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        w_load  = 1'b1;
        w_data  = ctr_data_out;
        w_mode  = mode_q;
        w_rst   = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_pop) state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_LOAD: begin
                        if (arg_q > MAX_ARG) begin
                            err     = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            w_data  = arg_q;
                            state_d = S_DONE;
                        end
                    end
                    OP_UP, OP_DOWN: begin
                        if (arg_q == 4'd0) begin
                            state_d = S_DONE;
                        end else begin
                            w_load  = 1'b0;
                            w_mode  = (op_q == OP_UP);
                            steps_d = arg_q - 4'd1;
                            state_d = (arg_q == 4'd1) ? S_DONE : S_COUNT;
                        end
                    end
                    default: begin
                        w_rst   = 1'b0;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_COUNT: begin
                w_load  = 1'b0;
                steps_d = steps_q - 4'd1;
                if (steps_q == 4'd1) state_d = S_DONE;
            end
            default: begin
                done    = 1'b1;
                state_d = w_pop ? S_EXEC : S_IDLE;
            end
        endcase
    end

    assign ctr_load    = reset_n & w_load;
    assign ctr_data_in = reset_n ? w_data : 4'd0;
    assign ctr_mode    = w_mode;
    assign ctr_reset_n = reset_n & w_rst;
    assign done_value  = done ? ctr_data_out : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_mod14_count_ctrl.sv
// ============================================================================
// Module      : tb_mod14_count_ctrl
// Description : Self-checking bench for mod14_count_ctrl with an attached
//               mod-14 counter and an arithmetic reference of command results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod14_count_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_arg = 4'd0;
    logic       cmd_ready;
    logic [3:0] ctr_data_in;
    logic       ctr_load, ctr_mode, ctr_reset_n;
    logic [3:0] ctr_data_out;
    logic       done, err, busy;
    logic [3:0] done_value;
    logic [2:0] fifo_count;
    logic [3:0] ctr_q;

    int n_checks = 0;
    int n_fail   = 0;
    int model_val = 0;

    always #5 clock = ~clock;

    mod14_count_ctrl #(.FIFO_DEPTH(4), .MAX_VAL(13)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .ctr_data_in(ctr_data_in), .ctr_load(ctr_load),
        .ctr_mode(ctr_mode), .ctr_reset_n(ctr_reset_n),
        .ctr_data_out(ctr_data_out),
        .done(done), .done_value(done_value), .err(err),
        .busy(busy), .fifo_count(fifo_count)
    );

    // The counter being controlled.
    always @(posedge clock) begin
        if (!ctr_reset_n)  ctr_q <= 4'd0;
        else if (ctr_load) ctr_q <= ctr_data_in;
        else if (ctr_mode) ctr_q <= (ctr_q == 4'd13) ? 4'd0 : ctr_q + 4'd1;
        else               ctr_q <= (ctr_q == 4'd0) ? 4'd13 : ctr_q - 4'd1;
    end
    assign ctr_data_out = ctr_q;

    // Result of a command: kind 1 = done with value, 2 = error (value unchanged).
    task automatic model_cmd(input logic [1:0] op, input logic [3:0] arg,
                             output int kind, output int val);
        kind = 1;
        case (op)
            2'b00: if (arg > 13) kind = 2; else model_val = arg;
            2'b01: model_val = (model_val + arg) % 14;
            2'b10: model_val = (model_val - (arg % 14) + 14) % 14;
            default: model_val = 0;
        endcase
        val = model_val;
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        for (int t = 0; t < 300 && !cmd_ready; t++) @(negedge clock);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Waits for the next done or err pulse; kind 0 means nothing arrived.
    task automatic wait_result(output int kind, output int val, output int cyc,
                               output int lowload, output int lowrst);
        kind = 0; val = 0; cyc = 0; lowload = 0; lowrst = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clock);
            cyc++;
            if (!ctr_load)    lowload++;
            if (!ctr_reset_n) lowrst++;
            if (done) begin kind = 1; val = int'(done_value); break; end
            if (err)  begin kind = 2; val = int'(ctr_data_out); break; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({done, err, busy, fifo_count, ctr_load, ctr_mode, ctr_data_in, done_value, ctr_reset_n, cmd_ready} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: done=%b err=%b busy=%b cnt=%0d load=%b mode=%b din=%0d dv=%0d rstn=%b rdy=%b required all 0",
                     done, err, busy, fifo_count, ctr_load, ctr_mode, ctr_data_in, done_value, ctr_reset_n, cmd_ready);
        end
        reset_n = 1'b1;
        model_val = 0;
        @(negedge clock);
        n_checks++;
        if ({cmd_ready, ctr_load, ctr_reset_n, ctr_data_in, busy} !== {3'b111, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b load=%b rstn=%b din=%0d busy=%b required 1 1 1 0 0",
                     cmd_ready, ctr_load, ctr_reset_n, ctr_data_in, busy);
        end
    endtask

    task automatic test_load_hold();
        int k, v;
        model_cmd(2'b00, 4'd9, k, v);
        push(2'b00, 4'd9);
        @(negedge clock);
        n_checks++;
        if ({ctr_load, ctr_data_in} !== {1'b1, 4'd9}) begin
            n_fail++;
            $display("FAIL load_exec: load=%b din=%0d required 1 9", ctr_load, ctr_data_in);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b1 || int'(done_value) != v) begin
            n_fail++;
            $display("FAIL load_done: done=%b value=%0d required 1 %0d", done, done_value, v);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_checks++;
            if (int'(ctr_data_out) != model_val || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold: count=%0d done=%b required %0d 0", ctr_data_out, done, model_val);
            end
        end
    endtask

    task automatic test_up_wrap();
        int k, v, ok, ov, cyc, ll, lr;
        model_cmd(2'b00, 4'd12, k, v);
        push(2'b00, 4'd12);
        wait_result(ok, ov, cyc, ll, lr);
        n_checks++;
        if (ok != k || ov != v || cyc != 2) begin
            n_fail++;
            $display("FAIL load12: kind=%0d value=%0d cycles=%0d required %0d %0d 2", ok, ov, cyc, k, v);
        end
        model_cmd(2'b01, 4'd3, k, v);
        push(2'b01, 4'd3);
        wait_result(ok, ov, cyc, ll, lr);
        n_checks++;
        if (ok != k || ov != v || ll != 3 || cyc != 4) begin
            n_fail++;
            $display("FAIL up3_wrap: kind=%0d value=%0d lowload=%0d cycles=%0d required %0d %0d 3 4", ok, ov, ll, cyc, k, v);
        end
    endtask

    task automatic test_down_clear();
        int k, v, ok, ov, cyc, ll, lr;
        model_cmd(2'b00, 4'd2, k, v);
        push(2'b00, 4'd2);
        wait_result(ok, ov, cyc, ll, lr);
        model_cmd(2'b10, 4'd5, k, v);
        push(2'b10, 4'd5);
        wait_result(ok, ov, cyc, ll, lr);
        n_checks++;
        if (ok != k || ov != v) begin
            n_fail++;
            $display("FAIL down5: kind=%0d value=%0d required %0d %0d", ok, ov, k, v);
        end
        model_cmd(2'b11, 4'd7, k, v);
        push(2'b11, 4'd7);
        wait_result(ok, ov, cyc, ll, lr);
        n_checks++;
        if (ok != k || ov != v || lr != 1 || cyc != 2) begin
            n_fail++;
            $display("FAIL clear: kind=%0d value=%0d lowrst=%0d cycles=%0d required %0d %0d 1 2", ok, ov, lr, cyc, k, v);
        end
    endtask

    task automatic test_load_err();
        int k1, v1, k2, v2, o1, w1, o2, w2, cyc, ll, lr;
        model_cmd(2'b00, 4'd14, k1, v1);
        model_cmd(2'b00, 4'd4, k2, v2);
        push(2'b00, 4'd14);
        fork
            push(2'b00, 4'd4);
            begin
                wait_result(o1, w1, cyc, ll, lr);
                wait_result(o2, w2, cyc, ll, lr);
            end
        join
        n_checks++;
        if (o1 != k1 || w1 != v1) begin
            n_fail++;
            $display("FAIL load_err: kind=%0d value=%0d required %0d %0d", o1, w1, k1, v1);
        end
        n_checks++;
        if (o2 != k2 || w2 != v2) begin
            n_fail++;
            $display("FAIL load_after_err: kind=%0d value=%0d required %0d %0d", o2, w2, k2, v2);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops  [6];
        logic [3:0] args [6];
        int ek[6], ev[6], ok[6], ov[6], oc[6];
        int ll, lr;
        logic [1:0] op_t [6]  = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [3:0] arg_t [6] = '{4'd15, 4'd7, 4'd2, 4'd0, 4'd9, 4'd13};
        for (int i = 0; i < 6; i++) begin
            ops[i] = op_t[i];
            args[i] = arg_t[i];
            model_cmd(ops[i], args[i], ek[i], ev[i]);
        end
        push(ops[0], args[0]);
        fork
            begin
                for (int i = 1; i < 6; i++) begin
                    push(ops[i], args[i]);
                    if (i == 4) begin
                        n_checks++;
                        if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL fifo_full: count=%0d ready=%b required 4 0", fifo_count, cmd_ready);
                        end
                    end
                end
            end
            begin
                for (int i = 0; i < 6; i++) wait_result(ok[i], ov[i], oc[i], ll, lr);
            end
        join
        for (int i = 0; i < 6; i++) begin
            int gap;
            gap = ((ops[i] == 2'b01 || ops[i] == 2'b10) && args[i] != 0) ? 1 + int'(args[i]) : 2;
            n_checks++;
            if (ok[i] != ek[i] || ov[i] != ev[i] || (i > 0 && oc[i] != gap)) begin
                n_fail++;
                $display("FAIL b2b_%0d: kind=%0d value=%0d gap=%0d required %0d %0d %0d", i, ok[i], ov[i], oc[i], ek[i], ev[i], gap);
            end
        end
    endtask

    task automatic test_reset_mid();
        push(2'b01, 4'd10);
        push(2'b00, 4'd5);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ctr_reset_n, fifo_count, busy, done, cmd_ready} !== 7'd0) begin
            n_fail++;
            $display("FAIL mid_reset: rstn=%b cnt=%0d busy=%b done=%b rdy=%b required all 0",
                     ctr_reset_n, fifo_count, busy, done, cmd_ready);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_val = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_nodone: done=%b busy=%b required 0 0", done, busy);
            end
        end
        n_checks++;
        if (int'(ctr_data_out) != model_val || {ctr_load, ctr_data_in} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_hold: count=%0d load=%b din=%0d required %0d 1 0", ctr_data_out, ctr_load, ctr_data_in, model_val);
        end
    endtask

    task automatic test_random();
        int exp_k[$];
        int exp_v[$];
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [1:0] op;
                    logic [3:0] arg;
                    int k, v;
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    op  = 2'($urandom_range(0, 3));
                    arg = 4'($urandom_range(0, 15));
                    model_cmd(op, arg, k, v);
                    exp_k.push_back(k);
                    exp_v.push_back(v);
                    push(op, arg);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int ok, ov, cyc, ll, lr, k, v;
                    wait_result(ok, ov, cyc, ll, lr);
                    n_checks++;
                    if (exp_k.size() == 0) begin
                        n_fail++;
                        $display("FAIL rand_%0d: kind=%0d value=%0d required no result", i, ok, ov);
                    end else begin
                        k = exp_k.pop_front();
                        v = exp_v.pop_front();
                        if (ok != k || ov != v) begin
                            n_fail++;
                            $display("FAIL rand_%0d: kind=%0d value=%0d required %0d %0d", i, ok, ov, k, v);
                        end
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_up_wrap();
        test_down_clear();
        test_load_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
